// File: rtl/pwm_duty_decoder_if.sv
// Bundle of the control input, the PWM line and the measurement results
// exchanged between the PWM duty decoder and its user.
interface pwm_duty_decoder_if #(
    parameter int CNT_W = 16
) ();
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [3:0]       duty_tenths;
    logic             valid;
    logic             stuck;
    logic             overrun;
    logic             busy;

    // The user of the decoder drives the line and enable, and observes the results.
    modport master (
        output enable,
        output pwm_in,
        input  period_out,
        input  high_out,
        input  duty_tenths,
        input  valid,
        input  stuck,
        input  overrun,
        input  busy
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output period_out,
        output high_out,
        output duty_tenths,
        output valid,
        output stuck,
        output overrun,
        output busy
    );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of a synchronised PWM line and reports the
// duty cycle in tenths via a 4-step restoring divider; flags a stuck line.
module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                reset,
    pwm_duty_decoder_if.slave   bus
);

    localparam int               NUM_W     = CNT_W + 4;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_DIV,
        ST_STUCK
    } state_e;

    // Input synchroniser and edge history
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic sync_prev_q, sync_prev_d;

    // Free-running measurement counter and high-time latch
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] h_lat_q, h_lat_d;

    // Control state and divider working registers
    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_per_q, div_per_d;
    logic [CNT_W-1:0] div_high_q, div_high_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [3:0]       quo_q, quo_d;
    logic [1:0]       div_bit_q, div_bit_d;

    // Registered outputs
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [3:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    // Combinational helpers
    logic             rise;
    logic             fall;
    logic [NUM_W-1:0] num_init;
    logic [NUM_W-1:0] div_shift;
    logic             div_ge;
    logic [NUM_W-1:0] rem_step;
    logic [3:0]       quo_step;
    logic [3:0]       duty_clamped;

    assign rise = sync_q & ~sync_prev_q;
    assign fall = ~sync_q & sync_prev_q;

    // Adding half the period before dividing turns truncation into rounding.
    assign num_init = NUM_W'(h_lat_q) * NUM_W'(10) + NUM_W'(p_cnt_q >> 1);

    always_comb begin
        div_shift = {4'b0000, div_per_q} << div_bit_q;
        div_ge    = (rem_q >= div_shift);
        rem_step  = div_ge ? (rem_q - div_shift) : rem_q;
        quo_step  = quo_q;
        quo_step[div_bit_q] = div_ge;
        duty_clamped = (quo_step > 4'd10) ? 4'd10 : quo_step;
    end

    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        meta_d      = bus.pwm_in;
        sync_d      = meta_q;
        sync_prev_d = sync_q;

        p_cnt_d = p_cnt_q;
        if (rise) begin
            p_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (p_cnt_q != TIMEOUT_C) begin
            p_cnt_d = p_cnt_q + 1'b1;
        end

        h_lat_d = fall ? p_cnt_q : h_lat_q;

        state_d    = state_q;
        div_per_d  = div_per_q;
        div_high_d = div_high_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_bit_d  = div_bit_q;
        period_d   = period_q;
        high_d     = high_q;
        duty_d     = duty_q;
        stuck_d    = stuck_q;
        valid_d    = 1'b0;
        overrun_d  = 1'b0;

        if (!bus.enable) begin
            // Disabling abandons any running division; results keep their last values.
            state_d = ST_IDLE;
            stuck_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_MEAS;
                    end
                end

                ST_MEAS: begin
                    if (rise) begin
                        div_per_d  = p_cnt_q;
                        div_high_d = h_lat_q;
                        rem_d      = num_init;
                        quo_d      = 4'd0;
                        div_bit_d  = 2'd3;
                        state_d    = ST_DIV;
                    end else if (p_cnt_q == TIMEOUT_C) begin
                        state_d  = ST_STUCK;
                        stuck_d  = 1'b1;
                        period_d = '0;
                        high_d   = '0;
                        duty_d   = sync_q ? 4'd10 : 4'd0;
                        valid_d  = 1'b1;
                    end
                end

                ST_DIV: begin
                    rem_d     = rem_step;
                    quo_d     = quo_step;
                    div_bit_d = div_bit_q - 2'd1;
                    // A period that ends while dividing is dropped; the counter still restarts.
                    overrun_d = rise;
                    if (div_bit_q == 2'd0) begin
                        state_d  = ST_MEAS;
                        period_d = div_per_q;
                        high_d   = div_high_q;
                        duty_d   = duty_clamped;
                        valid_d  = 1'b1;
                    end
                end

                ST_STUCK: begin
                    if (rise) begin
                        stuck_d = 1'b0;
                        state_d = ST_MEAS;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_DIV);
    end

    // NOTE: non-blocking assignments make every flop sample the values of the
    // previous cycle, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            p_cnt_q     <= '0;
            h_lat_q     <= '0;
            state_q     <= ST_IDLE;
            div_per_q   <= '0;
            div_high_q  <= '0;
            rem_q       <= '0;
            quo_q       <= 4'd0;
            div_bit_q   <= 2'd0;
            period_q    <= '0;
            high_q      <= '0;
            duty_q      <= 4'd0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            p_cnt_q     <= p_cnt_d;
            h_lat_q     <= h_lat_d;
            state_q     <= state_d;
            div_per_q   <= div_per_d;
            div_high_q  <= div_high_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_bit_q   <= div_bit_d;
            period_q    <= period_d;
            high_q      <= high_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.period_out  = period_q;
    assign bus.high_out    = high_q;
    assign bus.duty_tenths = duty_q;
    assign bus.valid       = valid_q;
    assign bus.stuck       = stuck_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;

endmodule
